shift_reg_tx: RTL

Parallel-in, serial-out transmitter. It accepts a W-bit word over a valid/ready load handshake and shifts it out one bit per clock-enable pulse, either MSB-first or LSB-first. It is the transmit-side counterpart of the serial-in `shift_reg` receiver. When both blocks share CE and the same DIR value, the receiver's Q equals the transmitted word after W enable pulses. A one-entry holding register allows gapless back-to-back words.

---
 rtl/shift_reg_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/shift_reg_tx.sv
// Parallel-in, serial-out transmitter with a one-entry holding register.
// Words are shifted out MSB- or LSB-first, one bit per CE pulse, and back-to-back words follow each other with no gap.
module shift_reg_tx #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic         CE,
  input  logic         DIR,
  input  logic [W-1:0] LOAD_DATA,
  input  logic         LOAD_VALID,
  output logic         LOAD_READY,
  output logic         Q,
  output logic         FRAME,
  output logic         DONE,
  output logic         dbg_state
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dir_l_q, dir_l_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           hold_dir_q, hold_dir_d;
  logic           hold_full_q, hold_full_d;
  logic           q_q, q_d;
  logic           frame_q, frame_d;
  logic           done_q, done_d;
  logic           accept;
  logic           last_edge;

  // Load handshake: a word (with its DIR) is taken on any rising edge where
  // LOAD_VALID and LOAD_READY are both high; LOAD_READY depends only on hold_full_q.
  assign accept    = LOAD_VALID & ~hold_full_q;
  assign last_edge = (state_q == S_SHIFT) & CE & (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    dir_l_d     = dir_l_q;
    hold_d      = hold_q;
    hold_dir_d  = hold_dir_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sreg_d  = LOAD_DATA;
          dir_l_d = DIR;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (CE) begin
          if (cnt_q != CNT_LAST) begin
            sreg_d = dir_l_q ? {sreg_q[W-2:0], 1'b0} : {1'b0, sreg_q[W-1:1]};
            cnt_d  = cnt_q + CW'(1);
          end else begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (hold_full_q) begin
              sreg_d      = hold_q;
              dir_l_d     = hold_dir_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              sreg_d  = LOAD_DATA;
              dir_l_d = DIR;
            end else begin
              sreg_d  = '0;
              dir_l_d = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        // Only the final edge with an empty hold loads directly; any other accept parks the word.
        if (accept && !last_edge) begin
          hold_d      = LOAD_DATA;
          hold_dir_d  = DIR;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    frame_d = (state_d == S_SHIFT);
    q_d     = frame_d & (dir_l_d ? sreg_d[W-1] : sreg_d[0]);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      dir_l_q     <= 1'b0;
      hold_q      <= '0;
      hold_dir_q  <= 1'b0;
      hold_full_q <= 1'b0;
      q_q         <= 1'b0;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      dir_l_q     <= dir_l_d;
      hold_q      <= hold_d;
      hold_dir_q  <= hold_dir_d;
      hold_full_q <= hold_full_d;
      q_q         <= q_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
    end
  end

  assign LOAD_READY = ~hold_full_q;
  assign Q          = q_q;
  assign FRAME      = frame_q;
  assign DONE       = done_q;
  assign dbg_state  = state_q;

endmodule
